// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Misses freeze the pipeline through cache_stall_o until the line is resident.
module dcache_ctrl #(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          p1_addr_i,
  input  logic [31:0]          p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 cache_stall_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 27 - IW;

  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILL_OK} state_t;

  state_t state_q, state_d;

  logic [TW-1:0]        req_tag;
  logic [IW-1:0]        idx;
  logic [2:0]           word;
  logic [7:0]           word_base;
  logic                 req;
  logic                 hit;
  logic                 write_hit;
  logic                 refill_done;
  logic                 unused_addr_bits;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TW-1:0]        tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  assign req_tag          = p1_addr_i[31:5+IW];
  assign idx              = p1_addr_i[4+IW:5];
  assign word             = p1_addr_i[4:2];
  assign word_base        = {word, 5'b0};
  assign unused_addr_bits = ^p1_addr_i[1:0];

  assign req         = p1_MemRead_i | p1_MemWrite_i;
  assign hit         = req & valid_q[idx] & (tag_q[idx] == req_tag);
  assign write_hit   = (state_q == IDLE) & p1_MemWrite_i & hit;
  assign refill_done = (state_q == REFILL) & mem_ack_i;

  // Invalid lines read as zero so the load port is defined out of reset.
  assign p1_data_o     = valid_q[idx] ? data_q[idx][word_base +: 32] : 32'h0;
  assign cache_stall_o = (state_q != IDLE) | (req & ~hit);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill_done) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (refill_done) begin
      data_q[idx] <= mem_data_i;
      tag_q[idx]  <= req_tag;
    end else if (write_hit) begin
      data_q[idx][word_base +: 32] <= p1_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = '0;
    case (state_q)
      IDLE: begin
        if (req && !hit) state_d = MISS;
      end
      MISS: begin
        state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx], idx, 5'b0};
        mem_data_o   = data_q[idx];
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, 5'b0};
        if (mem_ack_i) state_d = REFILL_OK;
      end
      REFILL_OK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hit vectors from a table plus hand-written
// miss, eviction and reset sequences against a latency-programmable memory.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         cache_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(.LINES(32), .LINE_BITS(256)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i),
    .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o),
    .cache_stall_o(cache_stall_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [13];

  int total = 0;
  int bad   = 0;
  int wb_lat = 1;
  int rf_lat = 1;
  int mem_cnt = 0;

  logic [255:0] mem_store [int unsigned];

  logic         seen_wb;
  logic         seen_rf;
  logic [31:0]  wb_addr;
  logic [31:0]  rf_addr;
  logic [255:0] wb_data;
  logic [31:0]  done_data;
  int           stall_cnt;

  // Untouched lines read back as 0xC0DE0000 | byte address of each word.
  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem_store.exists(a)) return mem_store[a];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hC0DE_0000 | {16'h0, a[15:0]} | 32'(k * 4);
    return l;
  endfunction

  // Memory acknowledges on the Nth cycle of a request, N taken from wb_lat/rf_lat.
  always @(negedge clk_i) begin
    if (!rst_i || !mem_enable_o) begin
      mem_cnt   = 0;
      mem_ack_i = 1'b0;
    end else begin
      mem_cnt = mem_cnt + 1;
      if (mem_cnt >= (mem_write_o ? wb_lat : rf_lat)) begin
        mem_ack_i = 1'b1;
        mem_cnt   = 0;
        if (mem_write_o) mem_store[mem_addr_o] = mem_data_o;
        else             mem_data_i = mem_line(mem_addr_o);
      end else begin
        mem_ack_i = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents one request, waits out any stall and records the memory traffic seen.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int wl, input int rl);
    wb_lat = wl;
    rf_lat = rl;
    seen_wb = 1'b0;
    seen_rf = 1'b0;
    wb_addr = '0;
    rf_addr = '0;
    wb_data = '0;
    stall_cnt = 0;
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    p1_addr_i     = addr;
    p1_data_i     = wdata;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (mem_enable_o && mem_write_o && !seen_wb) begin
        seen_wb = 1'b1;
        wb_addr = mem_addr_o;
        wb_data = mem_data_o;
      end
      if (mem_enable_o && !mem_write_o && !seen_rf) begin
        seen_rf = 1'b1;
        rf_addr = mem_addr_o;
      end
      if (!cache_stall_o) break;
      stall_cnt++;
    end
    checkOutput("stall_released", 32'(cache_stall_o), 32'd0);
    checkOutput("idle_mem_enable", 32'(mem_enable_o), 32'd0);
    checkOutput("idle_mem_addr", mem_addr_o, 32'h0);
    done_data = p1_data_o;
    @(posedge clk_i);
    #1;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, 1'b1, 32'hC0DE_0044, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h44, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h46, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h40, 32'h0,         1'b1, 32'hC0DE_0040, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h48, 32'h0,         1'b1, 32'hC0DE_0048, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h50, 32'h0,         1'b1, 32'hC0DE_0050, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h54, 32'h0,         1'b1, 32'hC0DE_0054, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h58, 32'h0,         1'b1, 32'hC0DE_0058, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h5C, 32'h0,         1'b1, 32'hC0DE_005C, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h4C, 32'h0BAD_F00D, 1'b1, 32'hC0DE_004C, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h4C, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h60, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h44, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};

    rst_i = 1'b0;
    p1_addr_i = 32'h40;
    p1_data_i = 32'h0;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    #12;
    checkOutput("rst_stall", 32'(cache_stall_o), 32'd0);
    checkOutput("rst_mem_enable", 32'(mem_enable_o), 32'd0);
    checkOutput("rst_mem_write", 32'(mem_write_o), 32'd0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
    checkOutput("rst_mem_data_nonzero", 32'(|mem_data_o), 32'd0);
    checkOutput("rst_p1_data", p1_data_o, 32'h0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Cold read with a 10-cycle refill.
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1, 10);
    checkOutput("cold_stall_cycles", 32'(stall_cnt), 32'd13);
    checkOutput("cold_refill_seen", 32'(seen_rf), 32'd1);
    checkOutput("cold_refill_addr", rf_addr, 32'h40);
    checkOutput("cold_no_writeback", 32'(seen_wb), 32'd0);
    checkOutput("cold_load_data", done_data, 32'hC0DE_0040);

    for (int i = 0; i < 13; i++) begin
      p1_MemRead_i  = vecs[i].rd;
      p1_MemWrite_i = vecs[i].wr;
      p1_addr_i     = vecs[i].addr;
      p1_data_i     = vecs[i].wdata;
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d_stall", i), 32'(cache_stall_o), 32'(vecs[i].exp_stall));
      if (vecs[i].chk_data) checkOutput($sformatf("vec%0d_data", i), p1_data_o, vecs[i].exp_data);
      @(posedge clk_i);
      #1;
    end
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;

    // Dirty eviction of line 2 by a new tag.
    applyStimulus(1'b1, 1'b0, 32'h440, 32'h0, 3, 2);
    checkOutput("evict_stall_cycles", 32'(stall_cnt), 32'd8);
    checkOutput("evict_wb_seen", 32'(seen_wb), 32'd1);
    checkOutput("evict_wb_addr", wb_addr, 32'h40);
    checkOutput("evict_wb_word0", wb_data[0 +: 32], 32'hC0DE_0040);
    checkOutput("evict_wb_word1", wb_data[32 +: 32], 32'hDEAD_BEEF);
    checkOutput("evict_wb_word3", wb_data[96 +: 32], 32'h0BAD_F00D);
    checkOutput("evict_wb_word7", wb_data[224 +: 32], 32'hC0DE_005C);
    checkOutput("evict_refill_addr", rf_addr, 32'h440);
    checkOutput("evict_load_data", done_data, 32'hC0DE_0440);

    // The refilled 0x440 line is clean, so bringing 0x40 back skips the write-back.
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1, 1);
    checkOutput("clean_no_writeback", 32'(seen_wb), 32'd0);
    checkOutput("clean_stall_cycles", 32'(stall_cnt), 32'd4);
    applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, 1, 1);
    checkOutput("reload_hit_stall", 32'(stall_cnt), 32'd0);
    checkOutput("reload_data", done_data, 32'hDEAD_BEEF);

    // Store miss on a clean line, then eviction of the merged line.
    applyStimulus(1'b0, 1'b1, 32'h80, 32'h1234_5678, 1, 1);
    checkOutput("smiss_stall_cycles", 32'(stall_cnt), 32'd4);
    checkOutput("smiss_no_writeback", 32'(seen_wb), 32'd0);
    checkOutput("smiss_refill_addr", rf_addr, 32'h80);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1, 1);
    checkOutput("smiss_merged_word", done_data, 32'h1234_5678);
    applyStimulus(1'b1, 1'b0, 32'h84, 32'h0, 1, 1);
    checkOutput("smiss_other_word", done_data, 32'hC0DE_0084);
    applyStimulus(1'b1, 1'b0, 32'h480, 32'h0, 1, 1);
    checkOutput("smiss_evict_stall", 32'(stall_cnt), 32'd5);
    checkOutput("smiss_evict_wb_addr", wb_addr, 32'h80);
    checkOutput("smiss_evict_word0", wb_data[0 +: 32], 32'h1234_5678);
    checkOutput("smiss_evict_word1", wb_data[32 +: 32], 32'hC0DE_0084);

    // Reset pulse in the middle of a long refill.
    rf_lat = 50;
    p1_addr_i = 32'h100;
    p1_MemRead_i = 1'b1;
    repeat (4) @(negedge clk_i);
    checkOutput("midrst_enable_before", 32'(mem_enable_o), 32'd1);
    checkOutput("midrst_write_before", 32'(mem_write_o), 32'd0);
    #2;
    rst_i = 1'b0;
    p1_MemRead_i = 1'b0;
    #1;
    checkOutput("midrst_enable_after", 32'(mem_enable_o), 32'd0);
    checkOutput("midrst_stall_after", 32'(cache_stall_o), 32'd0);
    checkOutput("midrst_addr_after", mem_addr_o, 32'h0);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1, 1);
    checkOutput("postrst_invalid_stall", 32'(stall_cnt), 32'd4);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1, 1);
    checkOutput("postrst_same_addr_stall", 32'(stall_cnt), 32'd4);
    checkOutput("postrst_refill_addr", rf_addr, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data cache controller between the MEM stage and the off-chip data memory. It answers MEM-stage loads and stores, and on a miss it drives `cache_stall_o` high. That signal freezes PC and all pipeline registers until the line is resident. It is the responder end of the pipeline stall interface: PC and the pipeline registers consume `cache_stall_o` as their stall input.

## Interface
- `LINES`, 32: number of cache lines. Power of two. Index width `IW` = log2(`LINES`).
- `LINE_BITS`, 256: line size in bits (32 bytes, 8 words). Offset width = 5.
- `clk_i`  in  1  clock, all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `p1_addr_i`  in  32  byte address from MEM stage. Bits [1:0] are ignored.
- `p1_data_i`  in  32  store data.
- `p1_MemRead_i`  in  1  load request.
- `p1_MemWrite_i`  in  1  store request. Takes precedence if asserted together with `p1_MemRead_i`.
- `p1_data_o`  out  32  load data.
- `cache_stall_o`  out  1  pipeline stall.
- `mem_addr_o`  out  32  line-aligned memory address. Bits [4:0] are always 0.
- `mem_data_o`  out  256  write-back line.
- `mem_enable_o`  out  1  memory request, held until acknowledged.
- `mem_write_o`  out  1  1 = write-back, 0 = refill.
- `mem_data_i`  in  256  refill line, valid when `mem_ack_i` = 1.
- `mem_ack_i`  in  1  single-cycle completion pulse from memory.

## Operation
- Address split:
  - tag = `p1_addr_i`[31:5+IW]
  - index = `p1_addr_i`[4+IW:5]
  - word = `p1_addr_i`[4:2]
- Per-line storage is internal: valid bit, dirty bit, tag, `LINE_BITS` of data.
- req = `p1_MemRead_i` | `p1_MemWrite_i`.
- hit = req & valid[index] & (tag[index] == tag).
- `p1_data_o` is combinational: word `word` of line `index`, regardless of hit. The pipeline samples it only when `cache_stall_o` = 0.
- `cache_stall_o` = (state != IDLE) | (req & ~hit). It is combinational, so the stall appears in the same cycle as a missing request.
- Write hit in IDLE: the addressed word is updated and dirty[index] is set to 1 at the next edge. The other words are unchanged.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_OK.
  - IDLE → MISS when req & ~hit.
  - MISS (1 cycle, no memory request) → WRITEBACK if valid & dirty, else REFILL.
  - WRITEBACK:
    - Outputs: `mem_enable_o` = 1, `mem_write_o` = 1, `mem_addr_o` = {stored tag, index, 5'b0}, `mem_data_o` = stored line.
    - On `mem_ack_i` → REFILL.
  - REFILL:
    - Outputs: `mem_enable_o` = 1, `mem_write_o` = 0, `mem_addr_o` = {request tag, index, 5'b0}.
    - On `mem_ack_i`: store `mem_data_i`, set valid = 1, dirty = 0, tag = request tag. Next state REFILL_OK.
  - REFILL_OK (1 cycle, stall still 1) → IDLE.
  - Back in IDLE the request now hits and the stall drops. A store then merges its word and sets dirty.
- Outside WRITEBACK and REFILL: `mem_enable_o` = `mem_write_o` = 0, and `mem_addr_o` / `mem_data_o` are 0.
- Request inputs must stay stable while `cache_stall_o` = 1. The pipeline guarantees this because it is frozen.
- `mem_ack_i` outside WRITEBACK/REFILL is ignored.

## Timing
- Reset (`rst_i` = 0, async):
  - state = IDLE.
  - All valid and dirty bits are cleared. Tag and data contents are don't-care.
  - `cache_stall_o` = 0 with no request.
  - `mem_enable_o` = `mem_write_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0, `p1_data_o` = 0.
- Reset asserted mid-miss: the FSM returns to IDLE immediately and all lines are invalidated. Dirty data is discarded by design. `mem_enable_o` drops asynchronously.
- Hit latency: 0 stall cycles.
- Clean miss stall: 1 (MISS) + N_refill + 1 (REFILL_OK) + 1 (the request cycle) stall cycles. N_refill = cycles from REFILL entry to and including the `mem_ack_i` cycle.
- Dirty miss: add N_wb cycles for WRITEBACK.
- `mem_ack_i` in the first cycle of WRITEBACK/REFILL is legal and gives N = 1.
- No request (req = 0) in IDLE: no state change, stall = 0.

## Test plan
- Cold read, address 0x0000_0040, memory ack after 10 cycles → `mem_addr_o` = 0x40 with `mem_write_o` = 0. `cache_stall_o` is high for exactly 13 cycles. `p1_data_o` = word 0 of the refill line, and the stall is low on the following cycle.
- Store 0xDEAD_BEEF to 0x44 after that refill, then a load from 0x44 → 0 stall cycles for both. Load returns 0xDEAD_BEEF, and the other 7 words are unchanged.
- Load 0x0000_0440 (same index, new tag) with line 2 dirty → WRITEBACK first with `mem_addr_o` = 0x40, `mem_write_o` = 1, and `mem_data_o` containing 0xDEAD_BEEF in word 1. Then REFILL with `mem_addr_o` = 0x440. The line is clean afterwards.
- Store miss to a clean line 0x80 → refill, then word merged. A later eviction writes back the merged line.
- `rst_i` pulsed low during REFILL → `mem_enable_o` falls without waiting for a clock, stall falls to 0. A re-access to the same address misses again.
- `p1_MemRead_i` and `p1_MemWrite_i` both 1 on a hit → treated as a store (dirty set, word written).
